// File: rtl/ecsu_pkg.sv
// Shared types and constants for the sensor-pod frame decoder and the ECSU.
// Latency: n/a (types, constants and a pure checksum function only).
// Backpressure: n/a.
package ecsu_pkg;

    // Decoder position within the 5-byte sensor frame.
    typedef enum logic [2:0] {
        FS_HUNT   = 3'd0,
        FS_WIND   = 3'd1,
        FS_TEMP   = 3'd2,
        FS_FLAGS  = 3'd3,
        FS_CSUM   = 3'd4,
        FS_UPDATE = 3'd5
    } frame_state_e;

    // First byte of every frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Visibility codes; FAILSAFE drives the ECSU into HIGH_ALERT.
    typedef enum logic [1:0] {
        VIS_CLEAR    = 2'b00,
        VIS_HAZE     = 2'b01,
        VIS_FOG      = 2'b10,
        VIS_FAILSAFE = 2'b11
    } vis_code_e;

    // ECSU state encodings consumed downstream.
    typedef enum logic [1:0] {
        ECSU_NORMAL     = 2'b00,
        ECSU_CAUTION    = 2'b01,
        ECSU_ALERT      = 2'b10,
        ECSU_HIGH_ALERT = 2'b11
    } ecsu_state_e;

    // Frame checksum: XOR of the three payload bytes.
    function automatic logic [7:0] frame_csum(input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
        return b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable; flags when it sits at MAX.
// Latency: count updates on the clock edge; at_max is decoded from the registered count.
// Backpressure: none; clear has priority over enable, holding at MAX once reached.
module sat_counter #(
    parameter int unsigned MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == MAX_V);

    // Next count: clear wins, otherwise step up until the ceiling.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/weather_frame_decoder.sv
// Decodes 5-byte sensor frames into registered weather outputs and flags stale data.
// Latency: outputs and frame_valid change one edge after the checksum byte is accepted.
// Backpressure: rx_ready drops for the single UPDATE cycle only; bytes are never lost.
module weather_frame_decoder
    import ecsu_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT  = 16,
    parameter int unsigned STALE_TIMEOUT = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              thunderstorm,
    output logic [5:0]        wind,
    output logic [1:0]        visibility,
    output logic signed [7:0] temperature,
    output logic              frame_valid,
    output logic              checksum_error,
    output logic              sensor_stale,
    output logic [7:0]        error_count
);

    frame_state_e state_q, state_d;

    // Staged frame bytes, kept whole so the checksum covers every bit.
    logic [7:0] wind_stg_q, wind_stg_d;
    logic [7:0] temp_stg_q, temp_stg_d;
    logic [7:0] flags_stg_q, flags_stg_d;

    // Last good weather values.
    logic       th_q, th_d;
    logic [5:0] wind_q, wind_d;
    logic [1:0] vis_q, vis_d;
    logic [7:0] temp_q, temp_d;

    logic       frame_valid_q, frame_valid_d;
    logic       checksum_error_q, checksum_error_d;
    logic [7:0] error_count_q, error_count_d;

    logic accept;
    logic waiting;
    logic byte_timeout;
    logic reject;
    logic byte_cnt_clr;
    logic byte_cnt_en;
    logic byte_at_max;
    logic stale_clr;
    logic stale_at_max;

    assign rx_ready = (state_q != FS_UPDATE);
    assign accept   = rx_valid && rx_ready;
    assign waiting  = (state_q == FS_WIND) || (state_q == FS_TEMP) ||
                      (state_q == FS_FLAGS) || (state_q == FS_CSUM);

    // The inter-byte timer only runs while a frame is partially received.
    assign byte_cnt_clr = accept || !waiting;
    assign byte_cnt_en  = waiting && !accept;
    assign byte_timeout = waiting && byte_at_max;

    // The age of the last good frame restarts when it is published.
    assign stale_clr = (state_q == FS_UPDATE);

    sat_counter #(.MAX(BYTE_TIMEOUT)) u_byte_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (byte_cnt_clr),
        .en     (byte_cnt_en),
        .at_max (byte_at_max)
    );

    sat_counter #(.MAX(STALE_TIMEOUT)) u_stale_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (stale_clr),
        .en     (1'b1),
        .at_max (stale_at_max)
    );

    // Frame parser: next state, byte staging, publish on UPDATE, reject decisions.
    always_comb begin
        state_d       = state_q;
        wind_stg_d    = wind_stg_q;
        temp_stg_d    = temp_stg_q;
        flags_stg_d   = flags_stg_q;
        th_d          = th_q;
        wind_d        = wind_q;
        vis_d         = vis_q;
        temp_d        = temp_q;
        frame_valid_d = 1'b0;
        reject        = 1'b0;

        if (byte_timeout) begin
            // A timeout beats any byte presented on the same edge; that byte is not consumed.
            reject  = 1'b1;
            state_d = FS_HUNT;
        end else begin
            case (state_q)
                FS_HUNT: begin
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state_d = FS_WIND;
                    end
                end
                FS_WIND: begin
                    if (accept) begin
                        wind_stg_d = rx_data;
                        if (rx_data[7:6] != 2'b00) begin
                            reject  = 1'b1;
                            state_d = FS_HUNT;
                        end else begin
                            state_d = FS_TEMP;
                        end
                    end
                end
                FS_TEMP: begin
                    if (accept) begin
                        temp_stg_d = rx_data;
                        state_d    = FS_FLAGS;
                    end
                end
                FS_FLAGS: begin
                    if (accept) begin
                        flags_stg_d = rx_data;
                        if (rx_data[7:3] != 5'd0) begin
                            reject  = 1'b1;
                            state_d = FS_HUNT;
                        end else begin
                            state_d = FS_CSUM;
                        end
                    end
                end
                FS_CSUM: begin
                    if (accept) begin
                        if (rx_data == frame_csum(wind_stg_q, temp_stg_q, flags_stg_q)) begin
                            state_d = FS_UPDATE;
                        end else begin
                            reject  = 1'b1;
                            state_d = FS_HUNT;
                        end
                    end
                end
                FS_UPDATE: begin
                    th_d          = flags_stg_q[2];
                    vis_d         = flags_stg_q[1:0];
                    wind_d        = wind_stg_q[5:0];
                    temp_d        = temp_stg_q;
                    frame_valid_d = 1'b1;
                    state_d       = FS_HUNT;
                end
                default: begin
                    state_d = FS_HUNT;
                end
            endcase
        end
    end

    // Reject bookkeeping: one-cycle error pulse and a saturating count.
    always_comb begin
        checksum_error_d = reject;
        error_count_d    = error_count_q;
        if (reject && (error_count_q != 8'hFF)) begin
            error_count_d = error_count_q + 8'd1;
        end
    end

    // State, staging and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= FS_HUNT;
            wind_stg_q       <= '0;
            temp_stg_q       <= '0;
            flags_stg_q      <= '0;
            th_q             <= 1'b0;
            wind_q           <= '0;
            vis_q            <= '0;
            temp_q           <= '0;
            frame_valid_q    <= 1'b0;
            checksum_error_q <= 1'b0;
            error_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            wind_stg_q       <= wind_stg_d;
            temp_stg_q       <= temp_stg_d;
            flags_stg_q      <= flags_stg_d;
            th_q             <= th_d;
            wind_q           <= wind_d;
            vis_q            <= vis_d;
            temp_q           <= temp_d;
            frame_valid_q    <= frame_valid_d;
            checksum_error_q <= checksum_error_d;
            error_count_q    <= error_count_d;
        end
    end

    assign thunderstorm   = th_q;
    assign wind           = wind_q;
    assign temperature    = temp_q;
    assign sensor_stale   = stale_at_max;
    // Stale data forces the fail-safe code; the real value is kept for the next good frame.
    assign visibility     = stale_at_max ? VIS_FAILSAFE : vis_q;
    assign frame_valid    = frame_valid_q;
    assign checksum_error = checksum_error_q;
    assign error_count    = error_count_q;

endmodule

// File: tb/tb_weather_frame_decoder.sv
// Self-checking bench for weather_frame_decoder: directed scenarios plus random frames.
// Latency: checks sample on the falling edge, half a cycle after each rising edge.
// Backpressure: the byte driver holds rx_valid until rx_ready is seen high.
module tb_weather_frame_decoder;

    localparam int BT = 16;
    localparam int ST = 1000;
    localparam logic [7:0] SYNC = 8'hA5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              thunderstorm;
    logic [5:0]        wind;
    logic [1:0]        visibility;
    logic signed [7:0] temperature;
    logic              frame_valid;
    logic              checksum_error;
    logic              sensor_stale;
    logic [7:0]        error_count;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int ce_cnt = 0;
    int cyc = 0;

    // Reference model: last published weather {th, wind, vis, temp} and reject count.
    logic [16:0] exp_out;
    int          exp_err;

    weather_frame_decoder #(.BYTE_TIMEOUT(BT), .STALE_TIMEOUT(ST)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .thunderstorm   (thunderstorm),
        .wind           (wind),
        .visibility     (visibility),
        .temperature    (temperature),
        .frame_valid    (frame_valid),
        .checksum_error (checksum_error),
        .sensor_stale   (sensor_stale),
        .error_count    (error_count)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled just after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (frame_valid === 1'b1) fv_cnt++;
        if (checksum_error === 1'b1) ce_cnt++;
    end

    function automatic logic [16:0] wx(input logic th, input logic [5:0] w,
                                       input logic [1:0] v, input logic [7:0] t);
        return {th, w, v, t};
    endfunction

    function automatic logic [16:0] obs();
        return {thunderstorm, wind, visibility, temperature};
    endfunction

    function automatic int sat_inc(input int e);
        return (e >= 255) ? 255 : e + 1;
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        rx_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_out = '0;
        exp_err = 0;
    endtask

    // Present one byte from a falling edge; returns on the falling edge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 8) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 8) begin
            bad++;
            $display("FAIL send_byte_ready: rx_ready=%b required 1 within 8 cycles", rx_ready);
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int gap);
        send_byte(SYNC);
        repeat (gap) @(negedge CLK);
        send_byte(b1);
        repeat (gap) @(negedge CLK);
        send_byte(b2);
        repeat (gap) @(negedge CLK);
        send_byte(b3);
        repeat (gap) @(negedge CLK);
        send_byte(b4);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 17'd0) begin
            bad++; $display("FAIL reset_outputs: got %h required 0", obs());
        end
        total++;
        if ({rx_ready, frame_valid, checksum_error, sensor_stale} !== 4'b1000) begin
            bad++; $display("FAIL reset_status: got %b required 1000",
                            {rx_ready, frame_valid, checksum_error, sensor_stale});
        end
        total++;
        if (error_count !== 8'd0) begin
            bad++; $display("FAIL reset_error_count: got %0d required 0", error_count);
        end
    endtask

    task automatic test_good_frame();
        int fv0;
        fv0 = fv_cnt;
        send_frame(8'h0C, 8'h24, 8'h02, 8'h2A, 0);
        // B4 just transferred: decoder is in UPDATE, outputs not yet changed.
        total++;
        if ({rx_ready, frame_valid} !== 2'b00 || obs() !== exp_out) begin
            bad++; $display("FAIL good_update_cycle: ready/fv=%b out=%h required 00 out=%h",
                            {rx_ready, frame_valid}, obs(), exp_out);
        end
        exp_out = wx(1'b0, 6'd12, 2'b10, 8'd36);
        @(negedge CLK);
        total++;
        if (obs() !== exp_out) begin
            bad++; $display("FAIL good_outputs: got %h required %h", obs(), exp_out);
        end
        total++;
        if ({rx_ready, frame_valid} !== 2'b11) begin
            bad++; $display("FAIL good_fv_pulse: got %b required 11", {rx_ready, frame_valid});
        end
        @(negedge CLK);
        total++;
        if (fv_cnt - fv0 !== 1 || error_count !== 8'(exp_err)) begin
            bad++; $display("FAIL good_counts: fv=%0d err=%0d required 1 and %0d",
                            fv_cnt - fv0, error_count, exp_err);
        end
    endtask

    task automatic test_bad_checksum();
        int ce0;
        ce0 = ce_cnt;
        send_frame(8'h16, 8'hD3, 8'h07, 8'h00, 0);
        exp_err = sat_inc(exp_err);
        total++;
        if (checksum_error !== 1'b1 || error_count !== 8'(exp_err)) begin
            bad++; $display("FAIL badcsum_pulse: ce=%b err=%0d required 1 and %0d",
                            checksum_error, error_count, exp_err);
        end
        @(negedge CLK);
        total++;
        if (checksum_error !== 1'b0 || ce_cnt - ce0 !== 1 || obs() !== exp_out) begin
            bad++; $display("FAIL badcsum_after: ce=%b pulses=%0d out=%h required 0 1 %h",
                            checksum_error, ce_cnt - ce0, obs(), exp_out);
        end
    endtask

    task automatic test_bad_wind();
        send_byte(8'h13);
        send_byte(8'h55);
        send_byte(SYNC);
        send_byte(8'h40);
        exp_err = sat_inc(exp_err);
        total++;
        if (checksum_error !== 1'b1 || error_count !== 8'(exp_err) || obs() !== exp_out) begin
            bad++; $display("FAIL badwind: ce=%b err=%0d out=%h required 1 %0d %h",
                            checksum_error, error_count, obs(), exp_out, exp_err);
        end
    endtask

    task automatic test_byte_timeout();
        int ce0;
        ce0 = ce_cnt;
        send_byte(SYNC);
        send_byte(8'h0C);
        repeat (BT - 1) @(negedge CLK);
        total++;
        if (error_count !== 8'(exp_err) || ce_cnt != ce0) begin
            bad++; $display("FAIL timeout_early: err=%0d pulses=%0d required %0d 0",
                            error_count, ce_cnt - ce0, exp_err);
        end
        repeat (3) @(negedge CLK);
        exp_err = sat_inc(exp_err);
        total++;
        if (error_count !== 8'(exp_err) || ce_cnt - ce0 !== 1) begin
            bad++; $display("FAIL timeout_abort: err=%0d pulses=%0d required %0d 1",
                            error_count, ce_cnt - ce0, exp_err);
        end
        send_frame(8'h21, 8'hF6, 8'h05, 8'h21 ^ 8'hF6 ^ 8'h05, 0);
        @(negedge CLK);
        exp_out = wx(1'b1, 6'h21, 2'b01, 8'hF6);
        total++;
        if (obs() !== exp_out || error_count !== 8'(exp_err)) begin
            bad++; $display("FAIL timeout_recover: out=%h err=%0d required %h %0d",
                            obs(), error_count, exp_out, exp_err);
        end
        // Gaps one short of the timeout still complete a frame.
        send_frame(8'h0A, 8'h3C, 8'h02, 8'h0A ^ 8'h3C ^ 8'h02, BT - 1);
        @(negedge CLK);
        exp_out = wx(1'b0, 6'h0A, 2'b10, 8'h3C);
        total++;
        if (obs() !== exp_out || error_count !== 8'(exp_err)) begin
            bad++; $display("FAIL slow_frame: out=%h err=%0d required %h %0d",
                            obs(), error_count, exp_out, exp_err);
        end
    endtask

    task automatic test_stale();
        send_frame(8'h05, 8'h80, 8'h06, 8'h05 ^ 8'h80 ^ 8'h06, 0);
        @(negedge CLK);
        exp_out = wx(1'b1, 6'h05, 2'b10, 8'h80);
        repeat (ST - 1) @(negedge CLK);
        total++;
        if (sensor_stale !== 1'b0 || obs() !== exp_out) begin
            bad++; $display("FAIL stale_early: stale=%b out=%h required 0 %h",
                            sensor_stale, obs(), exp_out);
        end
        @(negedge CLK);
        total++;
        if (sensor_stale !== 1'b1 || obs() !== wx(1'b1, 6'h05, 2'b11, 8'h80)) begin
            bad++; $display("FAIL stale_assert: stale=%b out=%h required 1 %h",
                            sensor_stale, obs(), wx(1'b1, 6'h05, 2'b11, 8'h80));
        end
        send_frame(8'h3F, 8'h7F, 8'h01, 8'h3F ^ 8'h7F ^ 8'h01, 0);
        total++;
        if (sensor_stale !== 1'b1 || visibility !== 2'b11) begin
            bad++; $display("FAIL stale_hold_to_update: stale=%b vis=%b required 1 11",
                            sensor_stale, visibility);
        end
        @(negedge CLK);
        exp_out = wx(1'b0, 6'h3F, 2'b01, 8'h7F);
        total++;
        if (sensor_stale !== 1'b0 || obs() !== exp_out) begin
            bad++; $display("FAIL stale_clear: stale=%b out=%h required 0 %h",
                            sensor_stale, obs(), exp_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ce0;
        ce0 = ce_cnt;
        send_byte(SYNC);
        send_byte(8'h3F);
        send_byte(8'h11);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if (obs() !== 17'd0 || error_count !== 8'd0 ||
            {rx_ready, frame_valid, checksum_error, sensor_stale} !== 4'b1000) begin
            bad++; $display("FAIL midreset_values: out=%h err=%0d st=%b required 0 0 1000", obs(),
                            error_count, {rx_ready, frame_valid, checksum_error, sensor_stale});
        end
        RST = 1'b0;
        exp_out = '0;
        exp_err = 0;
        repeat (BT + 4) @(negedge CLK);
        total++;
        if (ce_cnt !== ce0 || error_count !== 8'd0) begin
            bad++; $display("FAIL midreset_no_error: pulses=%0d err=%0d required 0 0",
                            ce_cnt - ce0, error_count);
        end
    endtask

    task automatic test_back_to_back();
        int fv0;
        int c0;
        fv0 = fv_cnt;
        c0  = cyc;
        send_frame(8'h01, 8'h02, 8'h03, 8'h01 ^ 8'h02 ^ 8'h03, 0);
        send_frame(8'h11, 8'hA5, 8'h04, 8'h11 ^ 8'hA5 ^ 8'h04, 0);
        send_frame(8'h2B, 8'hC8, 8'h07, 8'h2B ^ 8'hC8 ^ 8'h07, 0);
        total++;
        if (cyc - c0 !== 17) begin
            bad++; $display("FAIL b2b_rate: last byte after %0d cycles required 17", cyc - c0);
        end
        @(negedge CLK);
        exp_out = wx(1'b1, 6'h2B, 2'b11, 8'hC8);
        total++;
        if (fv_cnt - fv0 !== 3 || obs() !== exp_out || error_count !== 8'(exp_err)) begin
            bad++; $display("FAIL b2b_frames: fv=%0d out=%h err=%0d required 3 %h %0d",
                            fv_cnt - fv0, obs(), error_count, exp_out, exp_err);
        end
    endtask

    task automatic test_saturation();
        int ce0;
        do_reset();
        ce0 = ce_cnt;
        for (int i = 0; i < 260; i++) begin
            send_byte(SYNC);
            send_byte(8'hC0);
            exp_err = sat_inc(exp_err);
            if (i == 253 || i == 254 || i == 259) begin
                total++;
                if (error_count !== 8'(exp_err)) begin
                    bad++; $display("FAIL saturation_%0d: err=%0d required %0d",
                                    i, error_count, exp_err);
                end
            end
        end
        @(negedge CLK);
        total++;
        if (ce_cnt - ce0 !== 260 || obs() !== 17'd0) begin
            bad++; $display("FAIL saturation_pulses: pulses=%0d out=%h required 260 0",
                            ce_cnt - ce0, obs());
        end
    endtask

    task automatic test_random();
        int fv0, ce0, exp_fv, exp_ce, since_good, kind, gap, ng;
        logic [5:0] w;
        logic [7:0] t, b1, b3, cs, g;
        logic       th;
        logic [1:0] v;
        do_reset();
        fv0 = fv_cnt; ce0 = ce_cnt; exp_fv = 0; exp_ce = 0; since_good = 0;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 4);
            if (since_good >= 15) kind = 0;
            gap = $urandom_range(0, 3);
            w  = 6'($urandom_range(0, 63));
            t  = 8'($urandom);
            th = 1'($urandom_range(0, 1));
            v  = 2'($urandom_range(0, 3));
            b1 = {2'b00, w};
            b3 = {5'b00000, th, v};
            cs = b1 ^ t ^ b3;
            since_good++;
            case (kind)
                0: begin
                    send_frame(b1, t, b3, cs, gap);
                    exp_out = wx(th, w, v, t);
                    exp_fv++;
                    since_good = 0;
                end
                1: begin
                    send_frame(b1, t, b3, cs ^ 8'($urandom_range(1, 255)), gap);
                    exp_err = sat_inc(exp_err); exp_ce++;
                end
                2: begin
                    send_byte(SYNC);
                    repeat (gap) @(negedge CLK);
                    send_byte({2'($urandom_range(1, 3)), w});
                    exp_err = sat_inc(exp_err); exp_ce++;
                end
                3: begin
                    send_byte(SYNC);
                    send_byte(b1);
                    send_byte(t);
                    send_byte({5'($urandom_range(1, 31)), th, v});
                    exp_err = sat_inc(exp_err); exp_ce++;
                end
                default: begin
                    ng = $urandom_range(1, 3);
                    for (int k = 0; k < ng; k++) begin
                        g = 8'($urandom);
                        if (g == SYNC) g = 8'h5A;
                        send_byte(g);
                    end
                end
            endcase
            repeat (2) @(negedge CLK);
            total++;
            if (obs() !== exp_out || error_count !== 8'(exp_err) ||
                fv_cnt - fv0 !== exp_fv || ce_cnt - ce0 !== exp_ce) begin
                bad++; $display("FAIL random_%0d kind %0d: out=%h err=%0d fv=%0d ce=%0d required %h %0d %0d %0d",
                                it, kind, obs(), error_count, fv_cnt - fv0, ce_cnt - ce0,
                                exp_out, exp_err, exp_fv, exp_ce);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_out = '0;
        exp_err = 0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_wind();
        test_byte_timeout();
        test_stale();
        test_reset_mid_frame();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weather_frame_decoder.md
# weather_frame_decoder

Receives the byte-serial frame stream from the environmental sensor pod and checks each frame for framing and checksum errors. On every good frame it updates the registered `thunderstorm`, `wind`, `visibility` and `temperature` signals that feed the ECSU. It also watches how old the last good frame is and forces a fail-safe visibility code when the data goes stale. It sits between the sensor link and the ECSU, on the producer side of the ECSU's weather inputs.

## Interface
- `BYTE_TIMEOUT`, default 16: idle cycles allowed between bytes inside a frame before the frame is aborted.
- `STALE_TIMEOUT`, default 1000: cycles without a good frame before `sensor_stale` asserts.
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_data` in 8: sensor byte.
- `rx_ready` out 1: decoder can accept a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `thunderstorm` out 1: registered weather output to the ECSU.
- `wind` out 6: registered weather output to the ECSU (unsigned).
- `visibility` out 2: registered weather output to the ECSU.
- `temperature` out 8 signed: registered weather output to the ECSU.
- `frame_valid` out 1: one-cycle pulse when the outputs update.
- `checksum_error` out 1: one-cycle pulse when a frame is rejected.
- `sensor_stale` out 1: no good frame within `STALE_TIMEOUT` cycles.
- `error_count` out 8: count of rejected frames; saturates at 255.

## Operation
- Frame is 5 bytes:
  - B0 = sync byte `0xA5`.
  - B1 = `{2'b00, wind}`.
  - B2 = `temperature`, two's complement.
  - B3 = `{5'b0, thunderstorm, visibility}`.
  - B4 = B1 ^ B2 ^ B3.
- FSM states: HUNT, WIND, TEMP, FLAGS, CSUM, UPDATE.
- HUNT: accepted bytes other than `0xA5` are dropped silently. `0xA5` moves to WIND.
- WIND: latch B1. If B1[7:6] != 0, reject the frame and go to HUNT. Otherwise go to TEMP.
- TEMP: latch B2, go to FLAGS.
- FLAGS: latch B3. If B3[7:3] != 0, reject and go to HUNT. Otherwise go to CSUM.
- CSUM:
  - Match: go to UPDATE.
  - Mismatch: reject and go to HUNT.
- UPDATE: copy the staged fields to the outputs, pulse `frame_valid`, clear the stale counter, go to HUNT.
- `0xA5` received inside a frame is ordinary data; it does not resync.
- Reject action (applies to every rejection): pulse `checksum_error` and increment `error_count` (saturating).
- Byte timeout:
  - The inter-byte counter clears on each accepted byte.
  - In WIND, TEMP, FLAGS or CSUM, reaching `BYTE_TIMEOUT` idle cycles rejects the frame and returns to HUNT.
  - The counter is inactive in HUNT.
- Stale counter:
  - Increments every cycle and saturates at `STALE_TIMEOUT`.
  - Clears in UPDATE.
  - `sensor_stale` = (count == `STALE_TIMEOUT`).
- While `sensor_stale`:
  - `visibility` is driven as `2'b11`, which pushes the ECSU to HIGH_ALERT.
  - The other outputs hold their last good values.
  - The next good frame clears the stale condition and restores the real visibility.
- The staged fields reach the outputs only in UPDATE; a rejected frame never changes them.

## Timing
- Reset values:
  - FSM = HUNT, `rx_ready` = 1.
  - All weather outputs = 0.
  - `frame_valid` = 0, `checksum_error` = 0, `sensor_stale` = 0.
  - `error_count` = 0, both counters = 0.
- `rx_ready` = 0 only while in UPDATE (one cycle); 1 otherwise.
- Latency: B4 accepted at edge N → UPDATE during cycle N → outputs and `frame_valid` change at edge N+1.
- Maximum frame rate is 6 cycles per frame. Back-to-back frames lose no bytes, because the source stalls during UPDATE.
- Rejection timing:
  - `checksum_error` asserts the cycle after the rejecting edge.
  - `error_count` is updated at that same edge.
- Rejection on timeout and a byte arriving on the same edge: the timeout wins, and the byte is treated as a HUNT byte on a later edge only if still presented.
- Reset mid-frame: the partial frame is discarded with no error count.
- Stale flag timing: asserts at edge `STALE_TIMEOUT` after the last UPDATE (or after reset). It deasserts at the edge that performs the next UPDATE.

## Structure
- Shared package `ecsu_pkg` holds:
  - the frame-state enum;
  - `SYNC_BYTE = 8'hA5`;
  - the `VIS_*` visibility codes;
  - the ECSU state encodings used by the ECSU.
- Sub-module `sat_counter`:
  - Parameterised max value, synchronous clear, enable, `at_max` output.
  - Instantiated twice: inter-byte timeout and stale timeout.
- Counter widths come from `$clog2` of the parameters.

## Test plan
- Good frame A5 0C 24 02 2A → at the edge after B4: `wind` = 12, `temperature` = 36, `visibility` = 10, `thunderstorm` = 0; `frame_valid` pulses once; `error_count` = 0.
- Frame A5 16 D3 07 with bad checksum 00 → outputs unchanged; `checksum_error` pulses; `error_count` = 1.
- Bytes 13 55 A5 then 40 (B1[7:6] != 0) → garbage before sync ignored; frame rejected at B1; `error_count` +1; outputs unchanged.
- A5 0C, then 16 idle cycles (`BYTE_TIMEOUT` = 16) → abort to HUNT; `error_count` +1; following complete frame decodes correctly.
- No frames for 1000 cycles → `sensor_stale` = 1 and `visibility` = 11 at cycle 1000; next good frame clears stale and restores the frame's visibility.
- `RST` asserted after B2 of a frame → all outputs return to reset values; no `checksum_error` pulse.
